uart_cmd_assembler: RTL and testbench

//  Sits directly downstream of the UART receiver. Consumes each received byte
//  and assembles 4-byte command frames: SYNC, CMD_HI, CMD_LO, CHK.

---
 rtl/uart_cmd_assembler.sv | 168 ++++++++++++++++
 tb/tb_uart_cmd_assembler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_assembler
// Description : Assembles 4-byte command frames {SYNC, CMD_HI, CMD_LO, CHK}
//               from the byte stream of a UART receiver. A frame is good when
//               CHK == ~(CMD_HI + CMD_LO), with the sum taken over 8 bits and
//               the carry dropped. A good frame updates the 16-bit command and
//               raises cmd_rdy_o.
//               Bad checksums and inter-byte timeouts each produce a one-cycle
//               frm_err_o pulse. A good frame that lands while cmd_rdy_o is
//               still set produces a one-cycle ovr_err_o pulse.
// Ports       : clk             system clock
//               rst_n           asynchronous active-low reset
//               rx_rdy_i        receiver byte-valid flag (level)
//               rx_data_i[7:0]  received byte
//               clr_rx_rdy_o    byte consumed (combinational, equals rx_rdy_i)
//               cmd_o[15:0]     last valid command {CMD_HI, CMD_LO}
//               cmd_rdy_o       new command available (level)
//               clr_cmd_rdy_i   consumer acknowledge, clears cmd_rdy_o
//               frm_err_o       1-cycle pulse: bad checksum or timeout
//               ovr_err_o       1-cycle pulse: command overrun
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_assembler #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 500000,
    parameter int unsigned TO_W      = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy_i,
    input  logic [7:0]  rx_data_i,
    output logic        clr_rx_rdy_o,
    output logic [15:0] cmd_o,
    output logic        cmd_rdy_o,
    input  logic        clr_cmd_rdy_i,
    output logic        frm_err_o,
    output logic        ovr_err_o
);

    localparam logic [TO_W-1:0] c_to_last = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [7:0]        hi_q,      hi_d;
    logic [7:0]        lo_q,      lo_d;
    logic [TO_W-1:0]   timer_q,   timer_d;
    logic [15:0]       cmd_q,     cmd_d;
    logic              cmd_rdy_q, cmd_rdy_d;
    logic              frm_err_q, frm_err_d;
    logic              ovr_err_q, ovr_err_d;

    logic [7:0]        w_sum;
    logic              w_chk_ok;
    logic              w_good;

    // Every byte presented is consumed in the same cycle.
    assign clr_rx_rdy_o = rx_rdy_i;

    assign w_sum    = hi_q + lo_q;
    assign w_chk_ok = (rx_data_i == ~w_sum);

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        timer_d   = timer_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        frm_err_d = 1'b0;
        ovr_err_d = 1'b0;
        w_good    = 1'b0;

        if (clr_cmd_rdy_i) begin
            cmd_rdy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_rdy_i && (rx_data_i == SYNC_BYTE)) begin
                    state_d = S_HI;
                end
            end
            S_HI: begin
                // SYNC_BYTE is ordinary data here; there is no resync.
                if (rx_rdy_i) begin
                    hi_d    = rx_data_i;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (rx_rdy_i) begin
                    lo_d    = rx_data_i;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (rx_rdy_i) begin
                    state_d = S_IDLE;
                    if (w_chk_ok) begin
                        w_good = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Inter-byte timer: idle-held, cleared by any accepted byte. An accept
        // in the expiry cycle takes priority over the timeout.
        if (state_q == S_IDLE) begin
            timer_d = '0;
        end else if (rx_rdy_i) begin
            timer_d = '0;
        end else if (timer_q == c_to_last) begin
            timer_d   = '0;
            state_d   = S_IDLE;
            frm_err_d = 1'b1;
        end else begin
            timer_d = timer_q + TO_W'(1);
        end

        // Setting cmd_rdy overrides a same-cycle clear.
        if (w_good) begin
            cmd_d     = {hi_q, lo_q};
            cmd_rdy_d = 1'b1;
            ovr_err_d = cmd_rdy_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hi_q      <= 8'h00;
            lo_q      <= 8'h00;
            timer_q   <= '0;
            cmd_q     <= 16'h0000;
            cmd_rdy_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            timer_q   <= timer_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            frm_err_q <= frm_err_d;
            ovr_err_q <= ovr_err_d;
        end
    end

    assign cmd_o     = cmd_q;
    assign cmd_rdy_o = cmd_rdy_q;
    assign frm_err_o = frm_err_q;
    assign ovr_err_o = ovr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_assembler
// Description : Testbench for uart_cmd_assembler. Directed frame scenarios are
//               followed by randomized traffic. A frame-level reference model
//               predicts every output on every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_assembler;

    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned TO_W    = 5;
    localparam logic [7:0]  SYNC    = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_cmd_rdy = 1'b0;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;
    logic        ovr_err;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: bytes of the partial frame and idle gap length.
    logic [7:0]  m_frame[$];
    int          m_gap;
    logic [15:0] m_cmd;
    logic        m_rdy;
    logic        m_frm;
    logic        m_ovr;

    always #5 clk = ~clk;

    uart_cmd_assembler #(
        .SYNC_BYTE (SYNC),
        .TIMEOUT   (TIMEOUT),
        .TO_W      (TO_W)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_rdy_i      (rx_rdy),
        .rx_data_i     (rx_data),
        .clr_rx_rdy_o  (clr_rx_rdy),
        .cmd_o         (cmd),
        .cmd_rdy_o     (cmd_rdy),
        .clr_cmd_rdy_i (clr_cmd_rdy),
        .frm_err_o     (frm_err),
        .ovr_err_o     (ovr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_frame.delete();
        m_gap = 0;
        m_cmd = 16'h0000;
        m_rdy = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
    endfunction

    // One clock edge of the frame-level behaviour.
    function automatic void model_edge(input logic rdy, input logic [7:0] d, input logic clr);
        logic [7:0] s;
        logic       good;
        good  = 1'b0;
        m_frm = 1'b0;
        m_ovr = 1'b0;
        if (rdy) begin
            if (m_frame.size() == 0) begin
                if (d == SYNC) m_frame.push_back(d);
            end else if (m_frame.size() < 3) begin
                m_frame.push_back(d);
            end else begin
                s = m_frame[1] + m_frame[2];
                if (d == ~s) begin
                    good  = 1'b1;
                    m_ovr = m_rdy;
                    m_cmd = {m_frame[1], m_frame[2]};
                end else begin
                    m_frm = 1'b1;
                end
                m_frame.delete();
            end
            m_gap = 0;
        end else if (m_frame.size() != 0) begin
            m_gap++;
            if (m_gap >= int'(TIMEOUT)) begin
                m_frm = 1'b1;
                m_frame.delete();
                m_gap = 0;
            end
        end
        if (good)     m_rdy = 1'b1;
        else if (clr) m_rdy = 1'b0;
    endfunction

    // Called 1 time unit after a rising edge; leaves at the same phase.
    task automatic step(input logic rdy, input logic [7:0] d, input logic clr);
        rx_rdy      = rdy;
        rx_data     = d;
        clr_cmd_rdy = clr;
        #1;
        chk("clr_rx_rdy", {31'd0, clr_rx_rdy}, {31'd0, rdy});
        @(posedge clk);
        model_edge(rdy, d, clr);
        #1;
        chk("cmd",     {16'd0, cmd},     {16'd0, m_cmd});
        chk("cmd_rdy", {31'd0, cmd_rdy}, {31'd0, m_rdy});
        chk("frm_err", {31'd0, frm_err}, {31'd0, m_frm});
        chk("ovr_err", {31'd0, ovr_err}, {31'd0, m_ovr});
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] h, input logic [7:0] l, input logic [7:0] c);
        send(SYNC);
        send(h);
        send(l);
        send(c);
    endtask

    task automatic do_reset();
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        #2;
        chk("rst_cmd",     {16'd0, cmd},     32'd0);
        chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        chk("rst_frm_err", {31'd0, frm_err}, 32'd0);
        chk("rst_ovr_err", {31'd0, ovr_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_byte(input logic [7:0] b);
        step(1'b1, b, ($urandom_range(0, 3) == 0));
        for (int i = 0; i < int'($urandom_range(0, 2)); i++)
            step(1'b0, 8'h00, ($urandom_range(0, 3) == 0));
    endtask

    initial begin
        logic [7:0] h;
        logic [7:0] l;
        logic [7:0] c;
        int         k;

        do_reset();

        // Test 1: basic good frame, one-cycle latency after the CHK byte.
        send(SYNC); send(8'h12); send(8'h34);
        chk("t1_pre_rdy", {31'd0, cmd_rdy}, 32'd0);
        send(8'hB9);
        chk("t1_cmd", {16'd0, cmd}, 32'h1234);
        chk("t1_rdy", {31'd0, cmd_rdy}, 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("t1_clr", {31'd0, cmd_rdy}, 32'd0);

        // Test 2: bad checksum, then recovery.
        send_frame(8'h12, 8'h34, 8'h00);
        chk("t2_frm", {31'd0, frm_err}, 32'd1);
        chk("t2_cmd", {16'd0, cmd}, 32'h1234);
        idle(1);
        chk("t2_frm_once", {31'd0, frm_err}, 32'd0);
        send_frame(8'h56, 8'h78, 8'h31);
        chk("t2_cmd2", {16'd0, cmd}, 32'h5678);
        step(1'b0, 8'h00, 1'b1);

        // Test 3: junk before a frame.
        send(8'h00); send(8'hFF); send(8'h5A);
        send_frame(8'hAB, 8'hCD, 8'h87);
        chk("t3_cmd", {16'd0, cmd}, 32'hABCD);
        step(1'b0, 8'h00, 1'b1);

        // Test 4: inter-byte timeout; the orphaned tail is ignored.
        send(SYNC); send(8'h12);
        idle(int'(TIMEOUT) - 1);
        chk("t4_no_early", {31'd0, frm_err}, 32'd0);
        idle(1);
        chk("t4_timeout", {31'd0, frm_err}, 32'd1);
        send(8'h34); send(8'hB9);
        chk("t4_ignored", {31'd0, cmd_rdy}, 32'd0);
        send_frame(8'h56, 8'h78, 8'h31);
        chk("t4_fresh", {16'd0, cmd}, 32'h5678);

        // Test 5: overrun, then set and clear in the same cycle.
        send_frame(8'h12, 8'h34, 8'hB9);
        chk("t5_ovr", {31'd0, ovr_err}, 32'd1);
        chk("t5_cmd", {16'd0, cmd}, 32'h1234);
        send(SYNC); send(8'hAB); send(8'hCD);
        step(1'b1, 8'h87, 1'b1);
        chk("t5_set_wins", {31'd0, cmd_rdy}, 32'd1);
        chk("t5_cmd3", {16'd0, cmd}, 32'hABCD);

        // Test 6: reset mid-frame, fresh frame, SYNC as data.
        send(SYNC); send(8'h12);
        do_reset();
        send(8'h34); send(8'hB9);
        chk("t6_after_rst", {31'd0, cmd_rdy}, 32'd0);
        send_frame(8'h56, 8'h78, 8'h31);
        chk("t6_fresh", {16'd0, cmd}, 32'h5678);
        step(1'b0, 8'h00, 1'b1);
        send_frame(8'hA5, 8'h00, 8'h5A);
        chk("t6_sync_data", {16'd0, cmd}, 32'hA500);
        send_frame(8'hA5, 8'h00, 8'h5B);
        chk("t6_bad_chk", {31'd0, frm_err}, 32'd1);

        // Randomized traffic.
        for (int it = 0; it < 250; it++) begin
            if (it == 125) do_reset();
            k = int'($urandom_range(0, 5));
            h = 8'($urandom);
            l = 8'($urandom);
            c = ~(h + l);
            case (k)
                0, 1: begin
                    rand_byte(SYNC); rand_byte(h); rand_byte(l); rand_byte(c);
                end
                2: begin
                    rand_byte(SYNC); rand_byte(h); rand_byte(l);
                    rand_byte(c ^ 8'($urandom_range(1, 255)));
                end
                3: rand_byte(8'($urandom));
                4: begin
                    rand_byte(SYNC);
                    for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                        rand_byte(8'($urandom));
                    for (int j = 0; j < int'(TIMEOUT) + int'($urandom_range(0, 3)); j++)
                        step(1'b0, 8'h00, 1'b0);
                end
                default: begin
                    for (int j = 0; j < int'($urandom_range(1, 5)); j++)
                        step(1'b0, 8'h00, ($urandom_range(0, 2) == 0));
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
